calc_keypad_encoder: RTL and testbench

//  Converts the raw calc_pkg::buttons_t keypad vector (one bit per key, asynchronous, bouncy)

---
 rtl/calc_keypad_encoder_pkg.sv | 38 +++
 rtl/calc_keypad_encoder_if.sv | 11 +
 rtl/calc_keypad_encoder_sync2.sv | 26 ++
 rtl/calc_keypad_encoder.sv | 126 ++++++++++++
 tb/tb_calc_keypad_encoder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/calc_keypad_encoder_pkg.sv
// Shared keypad types and the helpers that move between the raw key vector and key codes.
package calc_pkg;

  localparam int unsigned NumKeys = 23;

  // Bit i of buttons_t is the key whose active_button_t code is i+1.
  typedef logic [NumKeys-1:0] buttons_t;

  typedef enum logic [4:0] {
    B_NONE = 5'd0,
    B_ON,
    B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
    B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
    B_DOT,
    B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_OP_EQ,
    B_CLEAR, B_CLEAR_ENTRY, B_SIGN, B_PERCENT, B_SQRT, B_BKSP
  } active_button_t;

  // Lowest set bit wins, so B_ON has top priority.
  function automatic active_button_t buttons2active(input buttons_t b);
    active_button_t r;
    logic           found;
    r     = B_NONE;
    found = 1'b0;
    for (int unsigned i = 0; i < NumKeys; i++) begin
      if (b[i] && !found) begin
        r     = active_button_t'(5'(i + 1));
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic buttons_onehot(input buttons_t b);
    return (b != '0) && ((b & (b - buttons_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/calc_keypad_encoder_if.sv
// Key-event valid/ready handshake between the keypad encoder and its consumer.
interface calc_keypad_encoder_if import calc_pkg::*; ();

  logic           button_valid;
  active_button_t button;
  logic           button_ready;

  modport master (output button_valid, output button, input button_ready);
  modport slave  (input button_valid, input button, output button_ready);

endinterface

// File: rtl/calc_keypad_encoder_sync2.sv
// Parameterized-width two-flop synchronizer, synchronously cleared to zero.
module calc_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/calc_keypad_encoder.sv
// Debounces the raw keypad vector and emits one key event per physical press.
module calc_keypad_encoder import calc_pkg::*; #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  buttons_t       buttons_i,
  output logic           button_valid_o,
  output active_button_t button_o,
  input  logic           button_ready_i,
  output logic           busy_o
);

  localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} enc_state_e;

  enc_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  buttons_t       sample_q, sample_d;
  logic           valid_q, valid_d;
  active_button_t button_q, button_d;
  logic [1:0]     prime_q, prime_d;
  logic           armed_q, armed_d;
  buttons_t       s;

  calc_sync2 #(.Width(NumKeys)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (buttons_i),
    .q_o    (s)
  );

  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    button_d = button_q;
    armed_d  = armed_q;
    prime_d  = {prime_q[0], 1'b1};
    unique case (state_q)
      IDLE: begin
        // After reset, a key already held is ignored until a genuine all-released
        // sample arrives through the refilled synchronizer.
        if (!armed_q) begin
          if (prime_q[1] && s == '0) armed_d = 1'b1;
        end else if (s != '0) begin
          sample_d = s;
          cnt_d    = CntW'(1);
          state_d  = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s != sample_q) begin
          if (s == '0) begin
            state_d = IDLE;
          end else begin
            sample_d = s;
            cnt_d    = CntW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            if (sample_q[0]) begin
              button_d = B_ON;
              valid_d  = 1'b1;
              state_d  = PRESSED;
            end else if (buttons_onehot(sample_q)) begin
              button_d = buttons2active(sample_q);
              valid_d  = 1'b1;
              state_d  = PRESSED;
            end else begin
              cnt_d   = '0;
              state_d = RELEASE;
            end
          end
        end
      end
      PRESSED: begin
        if (button_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (s == '0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) state_d = IDLE;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      button_q <= B_NONE;
      prime_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      button_q <= button_d;
      prime_q  <= prime_d;
      armed_q  <= armed_d;
    end
  end

  assign button_valid_o = valid_q;
  assign button_o       = button_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_calc_keypad_encoder.sv
// Scoreboard bench for calc_keypad_encoder with DebounceCycles=4.
module tb_calc_keypad_encoder;
  import calc_pkg::*;

  localparam int unsigned Lat = 6;

  logic     clk = 1'b0;
  logic     rst_n;
  buttons_t buttons;
  logic     busy;
  int       checks = 0;
  int       failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    active_button_t key;
    int unsigned    cyc;
  } exp_t;
  exp_t sb[$];

  calc_keypad_encoder_if kif ();

  calc_keypad_encoder #(.DebounceCycles(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .buttons_i      (buttons),
    .button_valid_o (kif.button_valid),
    .button_o       (kif.button),
    .button_ready_i (kif.button_ready),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input buttons_t b, input int unsigned hold, input logic expect_ev,
                       input active_button_t key);
    @(posedge clk);
    #1 buttons = b;
    if (expect_ev) sb.push_back('{key: key, cyc: cyc + Lat});
    repeat (hold) @(posedge clk);
    #1 buttons = '0;
  endtask

  // Monitor: rst/valid/ready of the previous negedge equal the values seen at the posedge in between.
  logic           prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b0;
  active_button_t prev_btn = B_NONE;
  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      if (prev_v && prev_rdy)
        chk("valid_drop_after_accept", !kif.button_valid, int'(kif.button_valid), 0);
      else if (prev_v) begin
        chk("valid_held", kif.button_valid, int'(kif.button_valid), 1);
        chk("button_frozen", kif.button == prev_btn, int'(kif.button), int'(prev_btn));
      end
      if (kif.button_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1'b0, int'(kif.button), int'(B_NONE));
        end else begin
          e = sb.pop_front();
          chk("event_key", kif.button == e.key, int'(kif.button), int'(e.key));
          chk("event_cycle", cyc == e.cyc, int'(cyc), int'(e.cyc));
        end
      end
    end
    prev_v   = kif.button_valid;
    prev_rdy = kif.button_ready;
    prev_rst = rst_n;
    prev_btn = kif.button;
  end

  initial begin
    buttons          = '0;
    rst_n            = 1'b0;
    kif.button_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", !kif.button_valid, int'(kif.button_valid), 0);
    chk("reset_button", kif.button == B_NONE, int'(kif.button), 0);
    chk("reset_busy", !busy, int'(busy), 0);
    idle(5);

    // 1: clean press, single event
    press(buttons_t'(1) << (B_NUM_7 - 1), 20, 1'b1, B_NUM_7);
    idle(10);

    // 2: bounce, event timed from final rising edge
    @(posedge clk); #1 buttons = buttons_t'(1) << (B_OP_ADD - 1);
    @(posedge clk); #1 buttons = '0;
    @(posedge clk); #1 buttons = buttons_t'(1) << (B_OP_ADD - 1);
    @(posedge clk); #1 buttons = '0;
    @(posedge clk); #1 buttons = buttons_t'(1) << (B_OP_ADD - 1);
    sb.push_back('{key: B_OP_ADD, cyc: cyc + Lat});
    repeat (10) @(posedge clk);
    #1 buttons = '0;
    idle(10);

    // 3: backpressure, release before accept
    kif.button_ready = 1'b0;
    press(buttons_t'(1) << (B_DOT - 1), 8, 1'b1, B_DOT);
    repeat (10) @(posedge clk);
    #1 kif.button_ready = 1'b1;
    idle(10);

    // 4: chord gives no event; ON in a chord wins
    press((buttons_t'(1) << (B_NUM_1 - 1)) | (buttons_t'(1) << (B_NUM_2 - 1)), 10, 1'b0, B_NONE);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("chord_busy_release", busy, int'(busy), 1);
    @(negedge clk);
    chk("chord_idle_after_release", !busy, int'(busy), 0);
    idle(4);
    press((buttons_t'(1) << (B_ON - 1)) | (buttons_t'(1) << (B_OP_EQ - 1)), 8, 1'b1, B_ON);
    idle(10);

    // 5: reset while an event is pending
    kif.button_ready = 1'b0;
    @(posedge clk); #1 buttons = buttons_t'(1) << (B_NUM_3 - 1);
    sb.push_back('{key: B_NUM_3, cyc: cyc + Lat});
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_valid", !kif.button_valid, int'(kif.button_valid), 0);
    chk("midreset_busy", !busy, int'(busy), 0);
    chk("midreset_button", kif.button == B_NONE, int'(kif.button), 0);
    kif.button_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held_after_reset_idle", !busy, int'(busy), 0);
    end
    @(posedge clk); #1 buttons = '0;
    idle(8);
    press(buttons_t'(1) << (B_NUM_3 - 1), 6, 1'b1, B_NUM_3);
    idle(10);

    // 6: every key round-trips
    for (int k = 1; k <= 23; k++) begin
      buttons_t       b;
      active_button_t key;
      b   = buttons_t'(1) << (k - 1);
      key = active_button_t'(5'(k));
      chk("pkg_decode", buttons2active(b) == key, int'(buttons2active(b)), k);
      chk("pkg_onehot", buttons_onehot(b), int'(buttons_onehot(b)), 1);
      press(b, 6, 1'b1, key);
      idle(8);
    end

    idle(5);
    chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
